// File: rtl/lsu_bridge.sv
// lsu_bridge: memory-stage load/store unit to single-channel bus bridge.
// A one-entry posted write buffer absorbs stores without stalling the core;
// loads stall the core until the bus returns data. Pending writes always drain
// before a read is issued, which keeps program order without address compares.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   core_addr       memory-stage byte address
//   core_wdata      lane-aligned store data
//   core_wmask      byte write mask (all-zero mask means no store)
//   core_we/core_re store / load request
//   core_rdata      load data, held until the next read response
//   core_stall      combinational pipeline freeze
//   bus_req_*       registered bus request channel (valid/ready handshake)
//   bus_resp_*      read response channel (single-cycle valid pulse)
module lsu_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic [3:0]            core_wmask,
  input  logic                  core_we,
  input  logic                  core_re,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  output logic                  bus_req_we,
  output logic [DATA_WIDTH-1:0] bus_req_wdata,
  output logic [3:0]            bus_req_wstrb,
  input  logic                  bus_resp_valid,
  input  logic [DATA_WIDTH-1:0] bus_resp_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] RD_DONE = 2'd3;

  // Current state
  logic [1:0]            state;
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [3:0]            wb_mask;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Next state
  logic [1:0]            state_d;
  logic                  wb_valid_d;
  logic [ADDR_WIDTH-1:0] wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_d;
  logic [3:0]            wb_mask_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [DATA_WIDTH-1:0] core_rdata_d;
  logic                  bus_req_valid_d;
  logic [ADDR_WIDTH-1:0] bus_req_addr_d;
  logic                  bus_req_we_d;
  logic [DATA_WIDTH-1:0] bus_req_wdata_d;
  logic [3:0]            bus_req_wstrb_d;

  logic store_req;
  logic load_req;
  logic bus_hs;
  logic wb_accept;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wb_valid      <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      wb_mask       <= 4'b0;
      rd_addr       <= '0;
      core_rdata    <= '0;
      bus_req_valid <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_we    <= 1'b0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= 4'b0;
    end else begin
      state         <= state_d;
      wb_valid      <= wb_valid_d;
      wb_addr       <= wb_addr_d;
      wb_data       <= wb_data_d;
      wb_mask       <= wb_mask_d;
      rd_addr       <= rd_addr_d;
      core_rdata    <= core_rdata_d;
      bus_req_valid <= bus_req_valid_d;
      bus_req_addr  <= bus_req_addr_d;
      bus_req_we    <= bus_req_we_d;
      bus_req_wdata <= bus_req_wdata_d;
      bus_req_wstrb <= bus_req_wstrb_d;
    end
  end

  // Next-state, stall and bus request logic
  always_comb begin
    state_d         = state;
    wb_valid_d      = wb_valid;
    wb_addr_d       = wb_addr;
    wb_data_d       = wb_data;
    wb_mask_d       = wb_mask;
    rd_addr_d       = rd_addr;
    core_rdata_d    = core_rdata;
    bus_req_valid_d = 1'b0;
    bus_req_addr_d  = '0;
    bus_req_we_d    = 1'b0;
    bus_req_wdata_d = '0;
    bus_req_wstrb_d = 4'b0;
    core_stall      = 1'b0;

    store_req = core_we && (core_wmask != 4'b0);
    // A store takes priority: core_re alongside core_we is not a load.
    load_req  = core_re && !core_we;
    bus_hs    = bus_req_valid && bus_req_ready;
    // Stores are only taken while the bus is free of a read, so an issued
    // read request can never be displaced by a write.
    wb_accept = store_req && !wb_valid && ((state == IDLE) || (state == RD_DONE));

    // Write buffer: drain on handshake, refill only from an empty buffer.
    if (wb_valid && bus_hs) begin
      wb_valid_d = 1'b0;
    end
    if (wb_accept) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = core_addr;
      wb_data_d  = core_wdata;
      wb_mask_d  = core_wmask;
    end

    // Read FSM
    case (state)
      IDLE: begin
        if (load_req && !wb_valid) begin
          state_d   = RD_REQ;
          rd_addr_d = core_addr;
        end
      end
      RD_REQ: begin
        if (bus_hs) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus_resp_valid) begin
          core_rdata_d = bus_resp_rdata;
          state_d      = RD_DONE;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Stall: blocked store, load launch in IDLE, or read in flight.
    if (store_req && !wb_accept) begin
      core_stall = 1'b1;
    end
    if ((state == IDLE) && load_req) begin
      core_stall = 1'b1;
    end
    if ((state == RD_REQ) || (state == RD_WAIT)) begin
      core_stall = 1'b1;
    end

    // Registered bus request built from next state; it only changes when the
    // buffer or FSM moves, so it is stable until handshake.
    if (wb_valid_d) begin
      bus_req_valid_d = 1'b1;
      bus_req_we_d    = 1'b1;
      bus_req_addr_d  = {wb_addr_d[ADDR_WIDTH-1:2], 2'b00};
      bus_req_wdata_d = wb_data_d;
      bus_req_wstrb_d = wb_mask_d;
    end else if (state_d == RD_REQ) begin
      bus_req_valid_d = 1'b1;
      bus_req_addr_d  = {rd_addr_d[ADDR_WIDTH-1:2], 2'b00};
    end
  end

endmodule
